// File: rtl/srff_pkg.sv
// Shared definitions for the srff set/reset flip-flop bank.
package srff_pkg;

  typedef enum logic [1:0] {
    SRFF_HOLD    = 2'd0,
    SRFF_SET_DOM = 2'd1,
    SRFF_RST_DOM = 2'd2,
    SRFF_TOGGLE  = 2'd3
  } srff_mode_t;

  localparam int unsigned SRFF_CNT_W = 16;

endpackage

// File: rtl/srff_cell.sv
// One SR storage bit: next-state function with parameter-selected s=r=1 policy
// and asynchronous active-low clear to RESET_BIT.
module srff_cell
  import srff_pkg::*;
#(
  parameter logic        RESET_BIT = 1'b0,
  parameter int unsigned BOTH_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);

  localparam srff_mode_t MODE = srff_mode_t'(BOTH_MODE);

  logic q_next;

  always_comb begin
    q_next = q;
    unique case ({s, r})
      2'b00: q_next = q;
      2'b10: q_next = 1'b1;
      2'b01: q_next = 1'b0;
      2'b11: begin
        unique case (MODE)
          SRFF_HOLD:    q_next = q;
          SRFF_SET_DOM: q_next = 1'b1;
          SRFF_RST_DOM: q_next = 1'b0;
          SRFF_TOGGLE:  q_next = ~q;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= RESET_BIT;
    else        q <= q_next;
  end

endmodule

// File: rtl/srff.sv
// Bank of WIDTH independent SR flip-flops with shared clock and async active-low reset.
// Optional macro SRFF_CONFLICT_EN adds registered conflict flags and a saturating conflict counter.
module srff
  import srff_pkg::*;
#(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       BOTH_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
`ifdef SRFF_CONFLICT_EN
  ,
  output logic [WIDTH-1:0]      conflict,
  output logic [SRFF_CNT_W-1:0] conflict_cnt
`endif
);

  if (BOTH_MODE > 3) begin : g_bad_mode
    $error("srff: BOTH_MODE=%0d is not a legal policy (0..3)", BOTH_MODE);
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("srff: WIDTH=%0d outside 1..64", WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    srff_cell #(
      .RESET_BIT(RESET_VAL[i]),
      .BOTH_MODE(BOTH_MODE)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i])
    );
  end

  assign qn = ~q;

`ifdef SRFF_CONFLICT_EN
  logic [WIDTH-1:0] both;
  assign both = s & r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      conflict <= both;
      if (|both && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_srff.sv
// Self-checking bench for srff: table-driven vectors across policy/width variants,
// plus hand sequences for async reset and (when SRFF_CONFLICT_EN) the conflict counter.
module tb_srff;

  logic       clk = 1'b0;
  logic       reset;
  logic       s1, r1;
  logic [7:0] s8, r8;

  logic q0, qn0, q1, qn1, q2, qn2, q3, qn3, qr, qnr;
  logic [7:0] q8, qn8;

`ifdef SRFF_CONFLICT_EN
  logic        c0, c1, c2, c3, cr;
  logic [7:0]  c8;
  logic [15:0] n0, n1, n2, n3, nr, n8;
`endif

  always #5 clk = ~clk;

  srff #(.WIDTH(1), .BOTH_MODE(0)) d0 (
    .clk(clk), .reset(reset), .s(s1), .r(r1), .q(q0), .qn(qn0)
`ifdef SRFF_CONFLICT_EN
    , .conflict(c0), .conflict_cnt(n0)
`endif
  );
  srff #(.WIDTH(1), .BOTH_MODE(1)) d1 (
    .clk(clk), .reset(reset), .s(s1), .r(r1), .q(q1), .qn(qn1)
`ifdef SRFF_CONFLICT_EN
    , .conflict(c1), .conflict_cnt(n1)
`endif
  );
  srff #(.WIDTH(1), .BOTH_MODE(2)) d2 (
    .clk(clk), .reset(reset), .s(s1), .r(r1), .q(q2), .qn(qn2)
`ifdef SRFF_CONFLICT_EN
    , .conflict(c2), .conflict_cnt(n2)
`endif
  );
  srff #(.WIDTH(1), .BOTH_MODE(3)) d3 (
    .clk(clk), .reset(reset), .s(s1), .r(r1), .q(q3), .qn(qn3)
`ifdef SRFF_CONFLICT_EN
    , .conflict(c3), .conflict_cnt(n3)
`endif
  );
  srff #(.WIDTH(1), .RESET_VAL(1'b1), .BOTH_MODE(0)) dr (
    .clk(clk), .reset(reset), .s(s1), .r(r1), .q(qr), .qn(qnr)
`ifdef SRFF_CONFLICT_EN
    , .conflict(cr), .conflict_cnt(nr)
`endif
  );
  srff #(.WIDTH(8), .BOTH_MODE(0)) d8 (
    .clk(clk), .reset(reset), .s(s8), .r(r8), .q(q8), .qn(qn8)
`ifdef SRFF_CONFLICT_EN
    , .conflict(c8), .conflict_cnt(n8)
`endif
  );

  typedef struct {
    logic       s1, r1;
    logic [7:0] s8, r8;
    logic       e0, e1, e2, e3, er;
    logic [7:0] e8;
  } vec_t;

  typedef struct {
    logic       e0, e1, e2, e3, er;
    logic [7:0] e8;
  } exp_t;

  vec_t v[12];
  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input logic e0, e1, e2, e3, er, input logic [7:0] e8);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3; e.er = er; e.e8 = e8;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got nothing want entry", tag);
      return;
    end
    n_cmp--;
    e = sb.pop_front();
    cmp({tag, " q0"},  {15'd0, q0},  {15'd0, e.e0});
    cmp({tag, " qn0"}, {15'd0, qn0}, {15'd0, ~e.e0});
    cmp({tag, " q1"},  {15'd0, q1},  {15'd0, e.e1});
    cmp({tag, " q2"},  {15'd0, q2},  {15'd0, e.e2});
    cmp({tag, " q3"},  {15'd0, q3},  {15'd0, e.e3});
    cmp({tag, " qr"},  {15'd0, qr},  {15'd0, e.er});
    cmp({tag, " qnr"}, {15'd0, qnr}, {15'd0, ~e.er});
    cmp({tag, " q8"},  {8'd0, q8},   {8'd0, e.e8});
    cmp({tag, " qn8"}, {8'd0, qn8},  {8'd0, ~e.e8});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //       s1 r1 s8     r8     e0 e1 e2 e3 er e8
    v[0]  = '{1, 0, 8'hF0, 8'h0F, 1, 1, 1, 1, 1, 8'hF0};
    v[1]  = '{0, 1, 8'h0C, 8'h30, 0, 0, 0, 0, 0, 8'hCC};
    v[2]  = '{0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hCC};
    v[3]  = '{1, 1, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hCC};
    v[4]  = '{1, 1, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hCC};
    v[5]  = '{1, 1, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hCC};
    v[6]  = '{1, 1, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hCC};
    v[7]  = '{1, 0, 8'h00, 8'hFF, 1, 1, 1, 1, 1, 8'h00};
    v[8]  = '{1, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 1, 8'h00};
    v[9]  = '{1, 1, 8'hFF, 8'hFF, 1, 1, 0, 1, 1, 8'h00};
    v[10] = '{1, 1, 8'hFF, 8'hFF, 1, 1, 0, 0, 1, 8'h00};
    v[11] = '{1, 0, 8'hAA, 8'h00, 1, 1, 1, 1, 1, 8'hAA};

    reset = 1'b0; s1 = 1'b0; r1 = 1'b0; s8 = '0; r8 = '0;
    push(0, 0, 0, 0, 1, 8'h00);
    #11;
    check_pop("reset");
    #1 reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      s1 = v[i].s1; r1 = v[i].r1; s8 = v[i].s8; r8 = v[i].r8;
      push(v[i].e0, v[i].e1, v[i].e2, v[i].e3, v[i].er, v[i].e8);
      @(posedge clk); #1;
      check_pop($sformatf("vec%0d", i));
    end

    // async clear between edges, held across an edge with set requested, then release
    #2 reset = 1'b0;
    push(0, 0, 0, 0, 1, 8'h00);
    #1 check_pop("async_clear");
    s1 = 1'b1; r1 = 1'b0; s8 = 8'hFF; r8 = 8'h00;
    push(0, 0, 0, 0, 1, 8'h00);
    @(posedge clk); #1 check_pop("reset_over_edge");
    s1 = 1'b0; r1 = 1'b0; s8 = 8'h00;
    #3 reset = 1'b1;
    push(0, 0, 0, 0, 1, 8'h00);
    @(posedge clk); #1 check_pop("release_hold");
    s1 = 1'b1; s8 = 8'hFF;
    push(1, 1, 1, 1, 1, 8'hFF);
    @(posedge clk); #1 check_pop("release_set");

`ifdef SRFF_CONFLICT_EN
    reset = 1'b0;
    #1;
    cmp("cnt_reset", n0, 16'h0000);
    cmp("conflict_reset", {15'd0, c0}, 16'h0000);
    s1 = 1'b1; r1 = 1'b1; s8 = 8'hF0; r8 = 8'h3C;
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cmp($sformatf("conflict_e%0d", i), {15'd0, c0}, 16'h0001);
      cmp($sformatf("cnt_e%0d", i), n0, 16'(i + 1));
      cmp($sformatf("conflict8_e%0d", i), {8'd0, c8}, 16'h0030);
    end
    s1 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1;
    cmp("conflict_clear", {15'd0, c0}, 16'h0000);
    cmp("cnt_hold", n0, 16'h0004);
    reset = 1'b0;
    #1 cmp("cnt_async_clear", n0, 16'h0000);
    #2 reset = 1'b1;
    s1 = 1'b1; r1 = 1'b1;
    repeat (65535) @(posedge clk);
    #1 cmp("cnt_full", n0, 16'hFFFF);
    @(posedge clk); #1;
    cmp("cnt_saturate", n0, 16'hFFFF);
    cmp("conflict_sat", {15'd0, c0}, 16'h0001);
`endif

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
